usb_ep_bank: RTL and testbench
==============================

Name: usb_ep_bank

Overview:
- Parametrised replacement for the per-endpoint usb_ep instances, the hand-written endpoint mux and the USB byte-pointer counter in the top level.
- Holds double-buffered state for EP_COUNT endpoints, each with an OUT and an IN direction.
- Drives toggle, handshake, bank and data-valid to the usb core, and generates the USB-side RAM address and write enable.
- Exposes all endpoint state to the CPU through a simple aaxi-style register port on clk_48.

Parameters:
EP_COUNT, 4, number of endpoints (1..16); endpoint numbers >= EP_COUNT are treated as absent
PKT_W, 6, log2 of max packet size; pointer is PKT_W+1 bits; RAM address is {ep, dir, bank, ptr[PKT_W-1:0]}
EP_W, 2, endpoint index width in the RAM address; must satisfy 2**EP_W >= EP_COUNT

Ports:
clk  in  1  clk_48 domain clock
rst_n  in  1  synchronous active-low reset
transaction_active  in  1  from usb core
endpoint  in  4  from usb core
direction_in  in  1  from usb core
setup  in  1  from usb core
data_strobe  in  1  from usb core, one byte transferred
success  in  1  from usb core, transaction ACKed
data_toggle  out  1  to usb core
handshake  out  2  to usb core: 00 ack, 01 none, 10 nak, 11 stall
data_in_valid  out  1  to usb core
ram_addr  out  EP_W+2+PKT_W  USB-side RAM address
ram_we  out  1  USB-side RAM write enable
avalid  in  1  CPU register access strobe
awe  in  1  1 = write
aaddr  in  6  word address: [5:2] endpoint, [0] direction (1 = IN)
adata  in  32  write data
bvalid  out  1  response valid
bdata  out  32  read data

Behaviour:
- Reset (rst_n low at clk edge):
  - all banks disarmed, all counts 0, bank pointers 0, toggles 0, stall 0;
  - ptr 0; bvalid 0; bdata 0.
- Byte pointer:
  - clears to 0 whenever !transaction_active;
  - on data_strobe increments, saturating at 2**PKT_W (bit PKT_W set stops the count).
- ram_we = data_strobe && !ptr[PKT_W] && !direction_in && endpoint < EP_COUNT.
- ram_addr combinational from endpoint, direction_in, the current bank pointer and ptr.
- Per direction state: armed[1:0], cnt0/cnt1 (PKT_W+1 bits each), bank, toggle, stall.
- Handshake selection (combinational, priority order):
  - endpoint absent -> stall, data_toggle 0, data_in_valid 0;
  - stall bit set and not setup -> stall;
  - current bank armed -> ack;
  - otherwise -> nak.
- data_in_valid = IN direction && current bank armed && ptr < cnt[bank].
- On success (one cycle):
  - OUT/SETUP: cnt[bank] <= ptr, armed[bank] <= 0, bank flips, toggle flips.
  - IN: armed[bank] <= 0, bank flips, toggle flips.
- SETUP success additionally:
  - clears stall on both directions of that endpoint;
  - forces IN toggle and OUT toggle to 1 (data stage starts DATA1).
- CPU write (avalid && awe):
  - [16] arm bank0 and [17] arm bank1; for IN, cnt of each armed bank <= adata[PKT_W:0];
  - [22] load toggle from [19];
  - [21] load stall from [20].
- Same-cycle collisions:
  - success disarm is applied first, CPU arm second, so the CPU wins;
  - CPU toggle load overrides the success flip.
- CPU read status word:
  - [6:0] cnt0, [14:8] cnt1, [16] armed0, [17] armed1, [18] bank, [19] toggle, [20] stall, other bits 0.
- Bus timing:
  - bvalid is asserted exactly 1 cycle after avalid, for both reads and writes;
  - bdata is registered in the same cycle as bvalid;
  - accesses to an absent endpoint return 0 and writes to it are ignored.
- Reset mid-transaction: all state clears; the usb core sees nak from the next cycle.

Optional Feature:
USB_EP_ISO_EN:
- When defined, status/control bit [24] is a per-direction iso flag. With iso set:
  - handshake is none instead of ack or nak;
  - toggle is held at 0;
  - success flips the bank without requiring it to be armed;
  - stall is ignored.
- When undefined, bit [24] reads 0 and writes to it are ignored.

Decomposition:
- Package usb_pkg:
  - handshake encodings hs_ack, hs_none, hs_nak, hs_stall;
  - status/control bit positions;
  - the per-direction state struct.
- Sub-module usb_ep_dir: one direction's state plus its success/CPU update logic.
  - Instantiated 2*EP_COUNT times in a generate loop.
  - The top level keeps the mux, the pointer and the bus.

Test Plan:
- CPU arms OUT ep1 bank0; host sends 8 bytes -> ram_we 8 pulses at addresses ep1/out/bank0/0..7, handshake ack; after success: cnt0 8, armed0 0, bank 1, toggle 1.
- Second OUT packet with no bank armed -> handshake nak, no ram_we, state unchanged.
- CPU arms IN ep0 bank0 with count 3 -> data_in_valid high for ptr 0..2, low at ptr 3; success -> bank 1, toggle flips.
- Set stall on ep0 OUT, then a SETUP arrives -> handshake not stall; after success stall 0 and both toggles 1.
- Access to endpoint 5 with EP_COUNT=4 -> handshake stall, ram_we 0; CPU read returns 0 with bvalid 1 cycle after avalid.
- CPU arm and success on the same bank in the same cycle -> bank ends armed; rst_n low mid-packet -> all status 0, next handshake nak.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types for the USB endpoint bank: handshake codes, register bit map
// and the per-direction endpoint state record.
package usb_pkg;

  typedef enum logic [1:0] {
    hs_ack   = 2'b00,
    hs_none  = 2'b01,
    hs_nak   = 2'b10,
    hs_stall = 2'b11
  } hs_e;

  // Width of each count field in the status word; PKT_W+1 must not exceed it.
  localparam int CNT_W = 7;

  // Status / control word bit positions
  localparam int B_CNT1    = 8;
  localparam int B_ARM0    = 16;
  localparam int B_ARM1    = 17;
  localparam int B_BANK    = 18;
  localparam int B_TOG     = 19;
  localparam int B_STALL   = 20;
  localparam int B_LDSTALL = 21;
  localparam int B_LDTOG   = 22;
  localparam int B_ISO     = 24;

  typedef struct packed {
    logic             iso;
    logic             stall;
    logic             toggle;
    logic             bank;
    logic [1:0]       armed;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt0;
  } ep_dir_t;

  // Pack one direction's state into the CPU-visible status word.
  function automatic logic [31:0] status_word(input ep_dir_t s);
    logic [31:0] w;
    w                  = '0;
    w[CNT_W-1:0]       = s.cnt0;
    w[B_CNT1+:CNT_W]   = s.cnt1;
    w[B_ARM0]          = s.armed[0];
    w[B_ARM1]          = s.armed[1];
    w[B_BANK]          = s.bank;
    w[B_TOG]           = s.toggle;
    w[B_STALL]         = s.stall;
    w[B_ISO]           = s.iso;
    return w;
  endfunction

endpackage

// File: rtl/usb_ep_dir.sv
// One direction (OUT or IN) of one endpoint: double-buffer arm/count state,
// bank pointer, data toggle and stall, updated by USB success and CPU writes.
// Optional isochronous mode is compiled in with USB_EP_ISO_EN.
module usb_ep_dir
  import usb_pkg::*;
#(
  parameter int PKT_W = 6,
  parameter bit IS_IN = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           succ_i,
  input  logic           setup_succ_i,
  input  logic [PKT_W:0] ptr_i,
  input  logic           wr_i,
  input  logic [31:0]    wdata_i,
  output ep_dir_t        st_o
);

  ep_dir_t st_q, st_d;

  // Only a subset of the control word applies to this direction.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  // Success retires the current bank first; CPU writes then override.
  always_comb begin
    st_d = st_q;
    if (succ_i) begin
      if (!IS_IN) begin
        if (st_q.bank) st_d.cnt1 = CNT_W'(ptr_i);
        else           st_d.cnt0 = CNT_W'(ptr_i);
      end
      st_d.armed[st_q.bank] = 1'b0;
      st_d.bank             = ~st_q.bank;
      st_d.toggle           = ~st_q.toggle;
    end
    // A completed SETUP restarts the control pipe: data stage is DATA1.
    if (setup_succ_i) begin
      st_d.stall  = 1'b0;
      st_d.toggle = 1'b1;
    end
    if (wr_i) begin
      if (wdata_i[B_ARM0]) begin
        st_d.armed[0] = 1'b1;
        if (IS_IN) st_d.cnt0 = CNT_W'(wdata_i[PKT_W:0]);
      end
      if (wdata_i[B_ARM1]) begin
        st_d.armed[1] = 1'b1;
        if (IS_IN) st_d.cnt1 = CNT_W'(wdata_i[PKT_W:0]);
      end
      if (wdata_i[B_LDTOG])   st_d.toggle = wdata_i[B_TOG];
      if (wdata_i[B_LDSTALL]) st_d.stall  = wdata_i[B_STALL];
`ifdef USB_EP_ISO_EN
      st_d.iso = wdata_i[B_ISO];
`endif
    end
`ifdef USB_EP_ISO_EN
    // Isochronous pipes never use DATA1.
    if (st_d.iso) st_d.toggle = 1'b0;
`endif
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) st_q <= '0;
    else        st_q <= st_d;
  end

  assign st_o = st_q;

endmodule

// File: rtl/usb_ep_bank.sv
// Endpoint bank: EP_COUNT endpoints x {OUT, IN} of double-buffered state,
// the USB-side byte pointer and RAM address, the handshake mux towards the
// usb core and a single-cycle CPU register port.
// Optional isochronous support: define USB_EP_ISO_EN.
module usb_ep_bank
  import usb_pkg::*;
#(
  parameter int EP_COUNT = 4,
  parameter int PKT_W    = 6,
  parameter int EP_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    transaction_active,
  input  logic [3:0]              endpoint,
  input  logic                    direction_in,
  input  logic                    setup,
  input  logic                    data_strobe,
  input  logic                    success,
  output logic                    data_toggle,
  output logic [1:0]              handshake,
  output logic                    data_in_valid,
  output logic [EP_W+2+PKT_W-1:0] ram_addr,
  output logic                    ram_we,
  input  logic                    avalid,
  input  logic                    awe,
  input  logic [5:0]              aaddr,
  input  logic [31:0]             adata,
  output logic                    bvalid,
  output logic [31:0]             bdata
);

  localparam int ND = 2 * EP_COUNT;

  ep_dir_t          st [ND];
  ep_dir_t          cur;
  logic             present;
  logic             cur_armed;
  logic [CNT_W-1:0] cur_cnt;
  hs_e              hs;
  logic [PKT_W:0]   ptr_q, ptr_d;
  logic [ND-1:0]    succ_v, setup_v, wr_v;
  logic [31:0]      rd_word;
  logic             bvalid_q, bvalid_d;
  logic [31:0]      bdata_q, bdata_d;

  // aaddr[1] carries no meaning in the word map.
  logic unused_aaddr;
  assign unused_aaddr = aaddr[1];

  // Per-direction state; index = 2*endpoint + direction_in
  for (genvar g = 0; g < ND; g++) begin : g_dir
    localparam int EP  = g / 2;
    localparam bit DIR = (g % 2) == 1;
    logic hit_ep;
    assign hit_ep     = present && (endpoint == 4'(EP));
    assign succ_v[g]  = success && hit_ep && (direction_in == DIR);
    assign setup_v[g] = success && setup && hit_ep;
    assign wr_v[g]    = avalid && awe && (aaddr[5:2] == 4'(EP)) && (aaddr[0] == DIR);

    usb_ep_dir #(.PKT_W(PKT_W), .IS_IN(DIR)) u_dir (
      .clk          (clk),
      .rst_n        (rst_n),
      .succ_i       (succ_v[g]),
      .setup_succ_i (setup_v[g]),
      .ptr_i        (ptr_q),
      .wr_i         (wr_v[g]),
      .wdata_i      (adata),
      .st_o         (st[g])
    );
  end

  // Select the direction the usb core is currently talking to
  always_comb begin
    present = 1'b0;
    cur     = '0;
    for (int e = 0; e < EP_COUNT; e++) begin
      if (endpoint == 4'(e)) begin
        present = 1'b1;
        cur     = direction_in ? st[2*e+1] : st[2*e];
      end
    end
  end

  // Handshake priority: absent, (iso), stall unless setup, armed, nak
  always_comb begin
    cur_armed = cur.armed[cur.bank];
    cur_cnt   = cur.bank ? cur.cnt1 : cur.cnt0;
    if (!present)                 hs = hs_stall;
`ifdef USB_EP_ISO_EN
    else if (cur.iso)             hs = hs_none;
`endif
    else if (cur.stall && !setup) hs = hs_stall;
    else if (cur_armed)           hs = hs_ack;
    else                          hs = hs_nak;
  end

  assign handshake     = hs;
  assign data_toggle   = present && cur.toggle;
  assign data_in_valid = present && direction_in && cur_armed && (CNT_W'(ptr_q) < cur_cnt);
  assign ram_addr      = {endpoint[EP_W-1:0], direction_in, cur.bank, ptr_q[PKT_W-1:0]};
  assign ram_we        = data_strobe && !ptr_q[PKT_W] && !direction_in && present;

  // Byte pointer: cleared between transactions, saturates at one full packet
  always_comb begin
    ptr_d = ptr_q;
    if (!transaction_active)              ptr_d = '0;
    else if (data_strobe && !ptr_q[PKT_W]) ptr_d = ptr_q + (PKT_W+1)'(1);
  end

  // Read mux; absent endpoints fall through to 0
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < ND; i++) begin
      if ((aaddr[5:2] == 4'(i / 2)) && (aaddr[0] == ((i % 2) == 1)))
        rd_word = status_word(st[i]);
    end
  end

  // Response one cycle after the access; writes return 0
  always_comb begin
    bvalid_d = avalid;
    bdata_d  = bdata_q;
    if (avalid) bdata_d = awe ? 32'h0 : rd_word;
  end

  // Pointer and bus response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      bvalid_q <= 1'b0;
      bdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      bvalid_q <= bvalid_d;
      bdata_q  <= bdata_d;
    end
  end

  assign bvalid = bvalid_q;
  assign bdata  = bdata_q;

endmodule

// File: tb/tb_usb_ep_bank.sv
// Directed bench for usb_ep_bank (EP_COUNT=4, PKT_W=6, EP_W=2).
module tb_usb_ep_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        transaction_active, direction_in, setup, data_strobe, success;
  logic [3:0]  endpoint;
  logic        data_toggle, data_in_valid, ram_we;
  logic [1:0]  handshake;
  logic [9:0]  ram_addr;
  logic        avalid, awe, bvalid;
  logic [5:0]  aaddr;
  logic [31:0] adata, bdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_ep_bank #(.EP_COUNT(4), .PKT_W(6), .EP_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .transaction_active(transaction_active), .endpoint(endpoint),
    .direction_in(direction_in), .setup(setup), .data_strobe(data_strobe),
    .success(success), .data_toggle(data_toggle), .handshake(handshake),
    .data_in_valid(data_in_valid), .ram_addr(ram_addr), .ram_we(ram_we),
    .avalid(avalid), .awe(awe), .aaddr(aaddr), .adata(adata),
    .bvalid(bvalid), .bdata(bdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] ep, input logic dir, input logic [31:0] d);
    avalid = 1'b1; awe = 1'b1; aaddr = {ep, 1'b0, dir}; adata = d;
    tick();
    check("wr_bvalid", {31'b0, bvalid}, 32'd1);
    avalid = 1'b0; awe = 1'b0; adata = '0;
    tick();
  endtask

  task automatic cpu_rd(input string tag, input logic [3:0] ep, input logic dir, input logic [31:0] exp);
    avalid = 1'b1; awe = 1'b0; aaddr = {ep, 1'b0, dir};
    #1 check({tag, "_bv_pre"}, {31'b0, bvalid}, 32'd0);
    tick();
    check({tag, "_bv"}, {31'b0, bvalid}, 32'd1);
    check(tag, bdata, exp);
    avalid = 1'b0;
    tick();
    check({tag, "_bv_post"}, {31'b0, bvalid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; transaction_active = 0; endpoint = 0; direction_in = 0;
    setup = 0; data_strobe = 0; success = 0;
    avalid = 0; awe = 0; aaddr = 0; adata = 0;

    // Reset state
    tick(); tick();
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_bdata", bdata, 32'd0);
    check("rst_hs", {30'b0, handshake}, 32'd2);
    check("rst_we", {31'b0, ram_we}, 32'd0);
    rst_n = 1'b1;
    tick();

    // OUT ep1: arm bank0, receive 8 bytes, ACK
    cpu_wr(4'd1, 1'b0, 32'h0001_0000);
    endpoint = 4'd1; direction_in = 1'b0; transaction_active = 1'b1;
    #1 check("out_hs_ack", {30'b0, handshake}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      data_strobe = 1'b1;
      #1;
      check("out_we", {31'b0, ram_we}, 32'd1);
      check("out_addr", {22'b0, ram_addr}, 32'h100 + k);
      tick();
    end
    data_strobe = 1'b0; success = 1'b1;
    tick();
    success = 1'b0; transaction_active = 1'b0;
    tick();
    cpu_rd("out_st", 4'd1, 1'b0, 32'h000C_0008);

    // Second OUT packet with nothing armed: NAK, state untouched
    transaction_active = 1'b1;
    #1 check("out2_hs_nak", {30'b0, handshake}, 32'd2);
    tick();
    transaction_active = 1'b0;
    tick();
    cpu_rd("out2_st", 4'd1, 1'b0, 32'h000C_0008);

    // IN ep0 bank0 with 3 bytes
    cpu_wr(4'd0, 1'b1, 32'h0001_0003);
    endpoint = 4'd0; direction_in = 1'b1; transaction_active = 1'b1;
    #1 check("in_hs_ack", {30'b0, handshake}, 32'd0);
    check("in_we", {31'b0, ram_we}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("in_div", {31'b0, data_in_valid}, (k < 3) ? 32'd1 : 32'd0);
      data_strobe = (k < 3);
      tick();
    end
    data_strobe = 1'b0; success = 1'b1;
    tick();
    success = 1'b0; transaction_active = 1'b0;
    tick();
    cpu_rd("in_st", 4'd0, 1'b1, 32'h000C_0003);

    // Stall ep0 OUT; stall ep0 IN and clear its toggle; then SETUP
    cpu_wr(4'd0, 1'b0, 32'h0030_0000);
    cpu_wr(4'd0, 1'b1, 32'h0070_0000);
    cpu_rd("stall_out_st", 4'd0, 1'b0, 32'h0010_0000);
    cpu_rd("stall_in_st", 4'd0, 1'b1, 32'h0014_0003);
    endpoint = 4'd0; direction_in = 1'b0; transaction_active = 1'b1;
    #1 check("stall_hs", {30'b0, handshake}, 32'd3);
    setup = 1'b1;
    #1 check("setup_hs", {30'b0, handshake}, 32'd2);
    data_strobe = 1'b1;
    tick(); tick();
    data_strobe = 1'b0; success = 1'b1;
    tick();
    success = 1'b0; setup = 1'b0; transaction_active = 1'b0;
    tick();
    cpu_rd("setup_out_st", 4'd0, 1'b0, 32'h000C_0002);
    cpu_rd("setup_in_st", 4'd0, 1'b1, 32'h000C_0003);

    // Absent endpoint 5
    endpoint = 4'd5; direction_in = 1'b0; transaction_active = 1'b1; data_strobe = 1'b1;
    #1 check("abs_hs", {30'b0, handshake}, 32'd3);
    check("abs_we", {31'b0, ram_we}, 32'd0);
    check("abs_tog", {31'b0, data_toggle}, 32'd0);
    data_strobe = 1'b0; direction_in = 1'b1;
    #1 check("abs_div", {31'b0, data_in_valid}, 32'd0);
    transaction_active = 1'b0;
    tick();
    cpu_rd("abs_rd", 4'd5, 1'b0, 32'h0);

    // Same-cycle success and CPU arm + toggle load on ep2 OUT bank0
    cpu_wr(4'd2, 1'b0, 32'h0001_0000);
    endpoint = 4'd2; direction_in = 1'b0; transaction_active = 1'b1; data_strobe = 1'b1;
    tick();
    data_strobe = 1'b0; success = 1'b1;
    avalid = 1'b1; awe = 1'b1; aaddr = {4'd2, 1'b0, 1'b0}; adata = 32'h0041_0000;
    tick();
    success = 1'b0; avalid = 1'b0; awe = 1'b0; adata = '0; transaction_active = 1'b0;
    tick();
    cpu_rd("coll_st", 4'd2, 1'b0, 32'h0005_0001);

    // Reset in the middle of an OUT packet on ep3
    cpu_wr(4'd3, 1'b0, 32'h0001_0000);
    endpoint = 4'd3; direction_in = 1'b0; transaction_active = 1'b1; data_strobe = 1'b1;
    tick(); tick();
    data_strobe = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 check("mid_hs_nak", {30'b0, handshake}, 32'd2);
    check("mid_addr", {22'b0, ram_addr}, 32'h300);
    check("mid_bvalid", {31'b0, bvalid}, 32'd0);
    transaction_active = 1'b0;
    tick();
    cpu_rd("mid_ep3", 4'd3, 1'b0, 32'h0);
    cpu_rd("mid_ep1", 4'd1, 1'b0, 32'h0);
    cpu_rd("mid_ep0in", 4'd0, 1'b1, 32'h0);
    cpu_rd("mid_ep2", 4'd2, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
